// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial subtract, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_c,
  output logic [WIDTH-1:0] quo_c
);

  logic [WIDTH+1:0] wide;
  logic             fits;

  always_comb begin
    wide  = {rem_in, quo_in[WIDTH-1]};
    fits  = (wide >= (WIDTH+2)'(dvs));
    rem_c = fits ? (WIDTH+1)'(wide - (WIDTH+2)'(dvs)) : (WIDTH+1)'(wide);
    quo_c = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to build two's-complement signed division instead of unsigned.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_q, rem_c;
  logic [WIDTH-1:0] quo_q, quo_c, dvs_q;
  logic [WIDTH-1:0] x_mag, y_mag, q_fin, r_fin;
  logic             accept_c, last_c, y_zero_c;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic neg_q, neg_r, ovf_pend, ovf_c;

  // Divide magnitudes, then restore signs: quotient by sign mismatch, remainder follows x.
  always_comb begin
    x_mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    y_mag = y[WIDTH-1] ? (~y + WIDTH'(1)) : y;
    ovf_c = (x == MOST_NEG) && (y == '1);
    q_fin = neg_q ? (~quo_c + WIDTH'(1)) : quo_c;
    r_fin = neg_r ? (~rem_c[WIDTH-1:0] + WIDTH'(1)) : rem_c[WIDTH-1:0];
  end
`else
  always_comb begin
    x_mag = x;
    y_mag = y;
    q_fin = quo_c;
    r_fin = rem_c[WIDTH-1:0];
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .dvs    (dvs_q),
    .rem_c  (rem_c),
    .quo_c  (quo_c)
  );

  assign accept_c = start && ((state == IDLE) || (state == DONE));
  assign last_c   = (cnt == LAST);
  assign y_zero_c = (y == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = y_zero_c ? DONE : RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    if (start) state_nxt = y_zero_c ? DONE : RUN;
               else       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; results only move on completion or a divide-by-zero accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quociente <= '0;
      resto     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_pend  <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (accept_c) begin
        cnt      <= '0;
        div_zero <= 1'b0;
        overflow <= 1'b0;
        if (y_zero_c) begin
          quociente <= '1;
          resto     <= x;
          div_zero  <= 1'b1;
        end else begin
          rem_q <= '0;
          quo_q <= x_mag;
          dvs_q <= y_mag;
`ifdef DIV_SIGNED_EN
          neg_q    <= x[WIDTH-1] ^ y[WIDTH-1];
          neg_r    <= x[WIDTH-1];
          ovf_pend <= ovf_c;
`endif
        end
      end else if (state == RUN) begin
        rem_q <= rem_c;
        quo_q <= quo_c;
        cnt   <= cnt + CW'(1);
        if (last_c) begin
          quociente <= q_fin;
          resto     <= r_fin;
`ifdef DIV_SIGNED_EN
          overflow  <= ovf_pend;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq; expectations follow DIV_SIGNED_EN when it is defined.
module tb_div_seq;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [W-1:0] quociente, resto;
  logic         busy, done, div_zero, overflow;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];

  div_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .quociente (quociente),
    .resto     (resto),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    e = '0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q  = a;
      e.ov = 1'b1;
    end else begin
      e.q = W'($signed(a) / $signed(b));
      e.r = W'($signed(a) % $signed(b));
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Launch one operation from the current time; returns edges to done (0 on timeout) and busy cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e,
                        output int lat, output int busy_n);
    x = a; y = b; start = 1'b1;
    exp_q.push_back(e);
    lat = 0; busy_n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0;
        x = ~a;
        y = $urandom;
      end
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({quociente, resto, busy, done, div_zero, overflow} !== '0)
      begin errors++; $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dz=%b ov=%b, want all 0",
                               quociente, resto, busy, done, div_zero, overflow); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bn; res_t e;
    @(negedge clk);
    run_op(32'd100, 32'd7, '{q: 32'd14, r: 32'd2, dz: 1'b0, ov: 1'b0}, lat, bn);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", lat); end
    checks++;
    if ({quociente, resto, div_zero, overflow} !== e)
      begin errors++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b ov=%b want q=%0d r=%0d dz=%b ov=%b",
                               quociente, resto, div_zero, overflow, e.q, e.r, e.dz, e.ov); end
    checks++;
    if (bn !== 32) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 32", bn); end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_single_pulse: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_div_zero();
    int lat, bn; res_t e;
    @(negedge clk);
    run_op(32'd5, 32'd0, '{q: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1, ov: 1'b0}, lat, bn);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 1 || bn !== 0) begin errors++; $display("FAIL zero_latency: got lat=%0d busy=%0d want 1 0", lat, bn); end
    checks++;
    if ({quociente, resto, div_zero, overflow} !== e)
      begin errors++; $display("FAIL zero_result: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                               quociente, resto, div_zero, overflow, e.q, e.r, e.dz, e.ov); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({quociente, resto, div_zero, overflow} !== e)
      begin errors++; $display("FAIL zero_hold: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                               quociente, resto, div_zero, e.q, e.r, e.dz); end
  endtask

  // A second start mid-RUN (with a zero divisor that would finish instantly) must be ignored.
  task automatic test_mid_run();
    int lat, dones; logic dz1; res_t e, got;
    @(negedge clk);
    x = 32'd1000; y = 32'd10; start = 1'b1;
    exp_q.push_back('{q: 32'd100, r: 32'd0, dz: 1'b0, ov: 1'b0});
    lat = 0; dones = 0; dz1 = 1'b1; got = '0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin start = 1'b0; dz1 = div_zero; end
      if (i == 10) begin start = 1'b1; x = 32'd77; y = 32'd0; end
      if (i == 11) start = 1'b0;
      if (done) begin
        dones++;
        if (lat == 0) begin lat = i; got = {quociente, resto, div_zero, overflow}; end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (dz1 !== 1'b0) begin errors++; $display("FAIL flag_clear_on_start: got dz=%b want 0", dz1); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL midrun_latency: got %0d want 33", lat); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL midrun_result: got %h want %h", got, e); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL midrun_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_wrap();
    int lat, bn; res_t e;
    @(negedge clk);
`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0, ov: 1'b0}, lat, bn);
`else
    run_op(32'hFFFF_FFF9, 32'd2, '{q: 32'h7FFF_FFFC, r: 32'd1, dz: 1'b0, ov: 1'b0}, lat, bn);
`endif
    e = exp_q.pop_front();
    checks++;
    if (lat !== 33 || {quociente, resto, div_zero, overflow} !== e)
      begin errors++; $display("FAIL wrap_result: got lat=%0d q=%h r=%h dz=%b ov=%b want lat=33 q=%h r=%h",
                               lat, quociente, resto, div_zero, overflow, e.q, e.r); end
  endtask

  task automatic test_most_neg();
    int lat, bn; res_t e;
    @(negedge clk);
`ifdef DIV_SIGNED_EN
    run_op(32'h8000_0000, 32'hFFFF_FFFF, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0, ov: 1'b1}, lat, bn);
`else
    run_op(32'h8000_0000, 32'hFFFF_FFFF, '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0, ov: 1'b0}, lat, bn);
`endif
    e = exp_q.pop_front();
    checks++;
    if (lat !== 33 || {quociente, resto, div_zero, overflow} !== e)
      begin errors++; $display("FAIL most_neg: got lat=%0d q=%h r=%h dz=%b ov=%b want lat=33 q=%h r=%h ov=%b",
                               lat, quociente, resto, div_zero, overflow, e.q, e.r, e.ov); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn, dones; res_t e;
    @(negedge clk);
    x = 32'd1000; y = 32'd7; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({quociente, resto, busy, done, div_zero, overflow} !== '0)
      begin errors++; $display("FAIL reset_mid_run: got q=%h r=%h busy=%b done=%b want all 0",
                               quociente, resto, busy, done); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL aborted_done: got %0d pulses want 0", dones); end
    @(negedge clk);
    run_op(32'd9, 32'd3, '{q: 32'd3, r: 32'd0, dz: 1'b0, ov: 1'b0}, lat, bn);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 33 || {quociente, resto, div_zero, overflow} !== e)
      begin errors++; $display("FAIL after_reset: got lat=%0d q=%0d r=%0d want lat=33 q=%0d r=%0d",
                               lat, quociente, resto, e.q, e.r); end
  endtask

  // Each new start is raised while the previous done is high, so it is accepted from DONE.
  task automatic test_back_to_back();
    int lat, bn; res_t e;
    logic [W-1:0] a, b;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      case (k)
        2:       b = '0;
        4:       b = W'($urandom_range(1, 5));
        5:       b = a + W'(1);
        default: b = W'($urandom_range(1, 1000));
      endcase
      run_op(a, b, model(a, b), lat, bn);
      e = exp_q.pop_front();
      checks++;
      if (lat !== ((b == '0) ? 1 : 33)) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d", k, lat); end
      checks++;
      if ({quociente, resto, div_zero, overflow} !== e)
        begin errors++; $display("FAIL b2b_result[%0d]: x=%h y=%h got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                                 k, a, b, quociente, resto, div_zero, overflow, e.q, e.r, e.dz, e.ov); end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_idle: got done=%b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_mid_run();
    test_wrap();
    test_most_neg();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse; operands sampled when accepted.
REQ-005 SHALL have port x  input  WIDTH  dividend.
REQ-006 SHALL have port y  input  WIDTH  divisor.
REQ-007 SHALL have port quociente  output  WIDTH  quotient, registered.
REQ-008 SHALL have port resto  output  WIDTH  remainder, registered.
REQ-009 SHALL have port busy  output  1  high while an operation is iterating.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-011 SHALL have port div_zero  output  1  registered flag, divisor was zero.
REQ-012 SHALL have port overflow  output  1  registered flag, signed overflow (always 0 without DIV_SIGNED_EN).

Function
REQ-013 SHALL implement restoring shift-subtract division, one quotient bit per clock.
REQ-014 SHALL use states IDLE, RUN, DONE; start accepted only in IDLE or DONE.
REQ-015 SHALL, on accepted start with y != 0, latch x and y, clear the iteration counter, and enter RUN.
REQ-016 SHALL stay in RUN exactly WIDTH cycles, then enter DONE; done high one cycle, WIDTH+1 cycles after the accepting edge.
REQ-017 SHALL assert busy in RUN only.
REQ-018 SHALL leave DONE for IDLE after one cycle unless start is high, in which case a new operation is accepted.
REQ-019 SHALL ignore start while in RUN; the operation in flight is not disturbed.
REQ-020 SHALL, on accepted start with y == 0, enter DONE next cycle with quociente = all ones, resto = x, div_zero = 1.
REQ-021 SHALL hold quociente, resto, div_zero, overflow stable from done until the next accepting edge.
REQ-022 SHALL clear div_zero and overflow on every accepted start.
REQ-023 SHALL hold the partial remainder in WIDTH+1 bits so the trial subtraction never loses the borrow.
REQ-024 SHALL leave x and y changes after the accepting edge without effect on the result.

Reset
REQ-025 SHALL, while reset is high, force state IDLE, counter 0, quociente 0, resto 0, busy 0, done 0, div_zero 0, overflow 0.
REQ-026 SHALL abort any operation in flight on reset with no done pulse; first start after reset release behaves as from power-up.

Configuration
REQ-027 SHALL compile signed (two's-complement) division when macro DIV_SIGNED_EN is defined.
REQ-028 SHALL, with DIV_SIGNED_EN, divide magnitudes, negate quotient if operand signs differ, give remainder the sign of x, same latency.
REQ-029 SHALL, with DIV_SIGNED_EN, return quociente = most-negative, resto = 0, overflow = 1 for most-negative / -1.
REQ-030 SHALL, without DIV_SIGNED_EN, treat operands as unsigned and tie overflow to 0.

Structure
REQ-031 SHALL place the state enum (IDLE, RUN, DONE) and default WIDTH constant in shared package div_pkg.
REQ-032 SHALL factor one restoring iteration (shift, trial subtract, select, quotient bit) into combinational sub-module div_step.

Verification
REQ-033 SHALL cover x=100, y=7 -> done 33 cycles after start, quociente=14, resto=2, flags 0.
REQ-034 SHALL cover x=5, y=0 -> done next cycle, quociente=0xFFFFFFFF, resto=5, div_zero=1.
REQ-035 SHALL cover x=0xFFFFFFF9, y=2 -> unsigned build quociente=0x7FFFFFFC, resto=1; DIV_SIGNED_EN build quociente=0xFFFFFFFD, resto=0xFFFFFFFF.
REQ-036 SHALL cover DIV_SIGNED_EN x=0x80000000, y=0xFFFFFFFF -> quociente=0x80000000, resto=0, overflow=1.
REQ-037 SHALL cover start pulsed mid-RUN with new operands -> first result unchanged, second start ignored, single done.
REQ-038 SHALL cover reset asserted at cycle 10 of RUN -> outputs zero immediately, no done, next x=9, y=3 yields quociente=3, resto=0.
